// File: rtl/fb_reader_if.sv
// Wishbone classic bus bundle shared by the frame-buffer reader and its memory slave.
// Clock and reset travel with the bus so the reader has a single timing reference.
interface wshb_if (
   input logic clk,
   input logic rst
);
   logic        stb;
   logic        cyc;
   logic        we;
   logic        ack;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;

   modport master (
      input  clk, rst, ack, dat_sm,
      output stb, cyc, adr, we, sel, cti, bte, dat_ms
   );

   modport slave (
      input  clk, rst, stb, cyc, adr, we, sel, cti, bte, dat_ms,
      output ack, dat_sm
   );
endinterface

// File: rtl/fb_reader.sv
// Frame-buffer reader: walks a frame in raster order over Wishbone classic reads
// and streams the fetched pixel words through a small FIFO with a start-of-frame flag.
module fb_reader #(
   parameter int unsigned HDISP      = 800,
   parameter int unsigned VDISP      = 480,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int unsigned FIFO_DEPTH = 16
) (
   wshb_if.master      wshb_ifm,
   input  logic        frame_restart,
   output logic [31:0] pix_data,
   output logic        pix_sof,
   output logic        pix_valid,
   input  logic        pix_ready
);
   localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
   localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [31:0] data;
      logic        sof;
   } pix_t;

   typedef enum logic [0:0] {S_IDLE, S_READ} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          w_stb;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [XW-1:0] w_x_nxt;
   logic [YW-1:0] w_y_nxt;
   logic [31:0]   r_adr;
   logic [31:0]   w_adr_nxt;
   logic          r_discard;
   pix_t          r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_ack;
   logic          w_push;
   logic          w_pop;
   logic          w_hold;

   assign w_ack     = wshb_ifm.ack && (r_state == S_READ);
   assign w_push    = w_ack && !r_discard && !frame_restart;
   assign w_pop     = (r_cnt != '0) && pix_ready && !frame_restart;
   assign w_cnt_nxt = frame_restart ? '0 : (r_cnt + CW'(w_push) - CW'(w_pop));
   assign w_hold    = (r_state == S_READ) && !wshb_ifm.ack;

   // Raster position of the next fetch; a restart forces (0,0) immediately.
   always_comb begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
      if (frame_restart) begin
         w_x_nxt = '0;
         w_y_nxt = '0;
      end else if (w_push) begin
         if (r_x == XW'(HDISP - 1)) begin
            w_x_nxt = '0;
            w_y_nxt = (r_y == YW'(VDISP - 1)) ? '0 : r_y + YW'(1);
         end else begin
            w_x_nxt = r_x + XW'(1);
         end
      end
   end

   assign w_adr_nxt = BASE_ADDR
                    + (32'(w_x_nxt) + 32'(w_y_nxt) * 32'(HDISP)) * 32'd4;

   always_ff @(posedge wshb_ifm.clk) begin
      if (wshb_ifm.rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (r_cnt < DEPTH_C) w_state_nxt = S_READ;
         S_READ:  if (wshb_ifm.ack) w_state_nxt = (w_cnt_nxt < DEPTH_C) ? S_READ : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_stb = 1'b0;
      if (r_state == S_READ) w_stb = 1'b1;
   end

   // Address is frozen while a request waits for its ack, even across a restart.
   always_ff @(posedge wshb_ifm.clk) begin
      if (wshb_ifm.rst) begin
         r_x       <= '0;
         r_y       <= '0;
         r_adr     <= BASE_ADDR;
         r_discard <= 1'b0;
      end else begin
         r_x <= w_x_nxt;
         r_y <= w_y_nxt;
         if (!w_hold) r_adr <= w_adr_nxt;
         if (w_ack) begin
            r_discard <= 1'b0;
         end else if (w_hold && frame_restart) begin
            r_discard <= 1'b1;
         end
      end
   end

   always_ff @(posedge wshb_ifm.clk) begin
      if (w_push) r_mem[r_wr] <= '{data: wshb_ifm.dat_sm, sof: (r_x == '0) && (r_y == '0)};
   end

   always_ff @(posedge wshb_ifm.clk) begin
      if (wshb_ifm.rst || frame_restart) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         r_cnt <= w_cnt_nxt;
      end
   end

   assign pix_valid = (r_cnt != '0);
   assign pix_data  = r_mem[r_rd].data;
   assign pix_sof   = pix_valid && r_mem[r_rd].sof;

   assign wshb_ifm.stb    = w_stb;
   assign wshb_ifm.cyc    = w_stb;
   assign wshb_ifm.adr    = r_adr;
   assign wshb_ifm.we     = 1'b0;
   assign wshb_ifm.sel    = 4'b1111;
   assign wshb_ifm.cti    = 3'b000;
   assign wshb_ifm.bte    = 2'b00;
   assign wshb_ifm.dat_ms = 32'h0;
endmodule

// File: doc/fb_reader.md
FB_READER -- requirements
Module: fb_reader

Interface
REQ-001 Parameter HDISP, default 800, pixels per line.
REQ-002 Parameter VDISP, default 480, lines per frame.
REQ-003 Parameter BASE_ADDR, default 0, byte address of pixel (0,0).
REQ-004 Parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of 2, >=2).
REQ-005 wshb_ifm.clk  input  1  single clock; all logic on rising edge.
REQ-006 wshb_ifm.rst  input  1  reset; synchronous, active-high.
REQ-007 wshb_ifm  wshb_if.master  -  Wishbone classic read master: stb, cyc, adr, we, sel, cti, bte, dat_ms out; ack, dat_sm in.
REQ-008 frame_restart  input  1  one-cycle pulse; resynchronise to pixel (0,0).
REQ-009 pix_data  output  32  head-of-FIFO pixel word.
REQ-010 pix_sof  output  1  head pixel is (0,0) of a frame.
REQ-011 pix_valid  output  1  FIFO not empty.
REQ-012 pix_ready  input  1  consumer accepts head pixel when pix_valid=1.

Function
REQ-013 Counters x_cnt (0..HDISP-1) and y_cnt (0..VDISP-1) give the next pixel to fetch.
REQ-014 adr = BASE_ADDR + (x_cnt + y_cnt*HDISP)*4, full 32-bit arithmetic, no truncation before the add.
REQ-015 Constant outputs: we=0, sel=4'b1111, cti=0, bte=0, dat_ms=0; cyc equals stb at all times.
REQ-016 FSM states: IDLE (stb=0) and READ (stb=1).
REQ-017 IDLE -> READ on the next edge when count < FIFO_DEPTH, where count is current FIFO occupancy.
REQ-018 In READ, stb and adr are held stable until ack; stb never drops without ack.
REQ-019 On ack in READ: push {dat_sm, sof=(x_cnt==0 && y_cnt==0)} into the FIFO; increment x_cnt.
REQ-020 On ack with x_cnt==HDISP-1: x_cnt=0 and y_cnt increments; with y_cnt==VDISP-1 also, y_cnt wraps to 0.
REQ-021 After ack: remain in READ if occupancy after the push-and-pop < FIFO_DEPTH, else go to IDLE.
REQ-022 One transaction outstanding at most, so a push never finds the FIFO full.
REQ-023 Pop when pix_valid && pix_ready; pix_data/pix_sof show the new head on the next cycle; no pop when empty.
REQ-024 Simultaneous push and pop in one cycle: occupancy unchanged and both take effect.
REQ-025 frame_restart in IDLE, or in READ with ack in the same cycle: flush FIFO (occupancy 0); x_cnt, y_cnt set to 0; any data acked that cycle is discarded.
REQ-026 frame_restart in READ without ack: flush FIFO and zero counters at once; keep stb high until ack; discard that ack's data; next fetch is (0,0).
REQ-027 A pop requested in the same cycle as frame_restart is dropped; the flush wins.
REQ-028 Throughput: with pix_ready held at 1 and ack returned the cycle after stb, sustained rate is one pixel per 2 cycles or better.

Reset
REQ-029 On rst: stb=0, cyc=0, state=IDLE, x_cnt=0, y_cnt=0, FIFO occupancy=0, pix_valid=0, pix_sof=0.
REQ-030 Reset overrides frame_restart and ack in the same cycle; an in-flight ack is abandoned without a push.
REQ-031 First stb is asserted 1 cycle after rst deasserts (IDLE -> READ since FIFO is empty).

Verification (HDISP=4, VDISP=2, FIFO_DEPTH=4, BASE_ADDR=0, slave acks 1 cycle after stb, dat_sm=adr)
REQ-032 Release reset, pix_ready=1 -> adr sequence 0,4,...,28,0,4; pix_data stream 0,4,...,28,0; pix_sof=1 only on data 0.
REQ-033 pix_ready=0 held -> exactly 4 acks, then stb=0 and stays 0; pix_valid=1; one pop -> exactly one more read, adr=16.
REQ-034 Ack withheld 5 cycles -> stb, cyc and adr stable through the wait; a single push on ack.
REQ-035 frame_restart while stb is waiting for ack at adr=12 -> stb held until ack, that data dropped, pix_valid=0, next adr=0 with pix_sof=1.
REQ-036 FIFO at 3 entries, push and pop in the same cycle -> occupancy stays 3; output order preserved.
REQ-037 rst asserted mid-READ -> next cycle stb=0 and pix_valid=0; after release, adr restarts at 0.
